// File: rtl/phase_pwm_channel.sv
// phase_pwm_channel: phase-shifted, duty-programmable PWM stage advanced by a synchronised tick.
// Define PWM_COMPLEMENT_EN to add pwm_out_n with DEADTIME dead-time insertion.
module phase_pwm_channel #(
   parameter int CNT_BITS    = 8,
   parameter int PERIOD      = 250,
   parameter int SYNC_STAGES = 2,
   parameter int DEADTIME    = 2
) (
   input  logic                clock_in,
   input  logic                reset,
   input  logic                tick_in,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CNT_BITS-1:0] cfg_phase,
   input  logic [CNT_BITS-1:0] cfg_duty,
   input  logic                cfg_enable,
   output logic                pwm_out,
`ifdef PWM_COMPLEMENT_EN
   output logic                pwm_out_n,
`endif
   output logic                period_start
);
   localparam int W = CNT_BITS + 1;
   localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(PERIOD - 1);
   localparam logic [W-1:0]        PER  = W'(PERIOD);

   if (PERIOD < 2 || PERIOD > 2**CNT_BITS || SYNC_STAGES < 2 || DEADTIME < 0) begin : g_bad_params
      $error("phase_pwm_channel: illegal parameter set");
   end

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_d, tick, wrap, xfer, raw;
   logic [CNT_BITS-1:0]    cnt, act_phase, act_duty, pend_phase, pend_duty;
   logic                   act_en, pend_en, pend_full;
   logic [W-1:0]           ph_eff, pos;

   assign tick = sync[SYNC_STAGES-1] & ~sync_d;
   assign wrap = tick & (cnt == LAST);
   assign xfer = cfg_valid & cfg_ready;

   // phase is clamped so the wrap-around subtraction never underflows
   always_comb begin
      ph_eff = (act_phase > LAST) ? {1'b0, LAST} : {1'b0, act_phase};
      pos    = ({1'b0, cnt} >= ph_eff) ? {1'b0, cnt} - ph_eff : {1'b0, cnt} + PER - ph_eff;
      raw    = act_en & (pos < {1'b0, act_duty});
   end

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         sync         <= '0;
         sync_d       <= 1'b0;
         cnt          <= '0;
         period_start <= 1'b0;
         act_phase    <= '0;
         act_duty     <= '0;
         act_en       <= 1'b0;
         pend_phase   <= '0;
         pend_duty    <= '0;
         pend_en      <= 1'b0;
         pend_full    <= 1'b0;
         cfg_ready    <= 1'b1;
      end else begin
         sync         <= {sync[SYNC_STAGES-2:0], tick_in};
         sync_d       <= sync[SYNC_STAGES-1];
         period_start <= wrap;
         if (tick)
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_BITS'(1);
         if (xfer) begin
            pend_phase <= cfg_phase;
            pend_duty  <= cfg_duty;
            pend_en    <= cfg_enable;
         end
         if (wrap & pend_full) begin
            act_phase <= pend_phase;
            act_duty  <= pend_duty;
            act_en    <= pend_en;
         end
         pend_full <= xfer | (pend_full & ~wrap);
         cfg_ready <= ~(xfer | (pend_full & ~wrap));
      end
   end

`ifdef PWM_COMPLEMENT_EN
   localparam int DW = $clog2(DEADTIME + 2);
   logic          raw_q;
   logic [DW-1:0] dt, dt_nxt;

   // any edge on raw reopens the dead window; outputs rise only once it has drained
   assign dt_nxt = (raw != raw_q) ? DW'(DEADTIME) : (dt != '0) ? dt - DW'(1) : '0;

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         raw_q     <= 1'b0;
         dt        <= '0;
         pwm_out   <= 1'b0;
         pwm_out_n <= 1'b0;
      end else begin
         raw_q     <= raw;
         dt        <= dt_nxt;
         pwm_out   <= (dt_nxt == '0) & raw;
         pwm_out_n <= (dt_nxt == '0) & ~raw & act_en;
      end
   end
`else
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset)
         pwm_out <= 1'b0;
      else
         pwm_out <= raw;
   end
`endif
endmodule

// File: tb/tb_phase_pwm_channel.sv
// tb_phase_pwm_channel: directed bench for phase_pwm_channel with PERIOD=8, CNT_BITS=4, tick = clock/4.
// One counter value spans 4 clock cycles, so one output period is 32 cycles.
module tb_phase_pwm_channel;
   logic       clock_in = 1'b0, reset = 1'b1, tick_in = 1'b0;
   logic       cfg_valid = 1'b0, cfg_enable = 1'b0;
   logic [3:0] cfg_phase = '0, cfg_duty = '0;
   logic       cfg_ready, pwm_out, period_start;
`ifdef PWM_COMPLEMENT_EN
   logic       pwm_out_n;
`endif
   int checks = 0, failures = 0;

   phase_pwm_channel #(.CNT_BITS(4), .PERIOD(8), .SYNC_STAGES(2), .DEADTIME(2)) dut (
      .clock_in    (clock_in),
      .reset       (reset),
      .tick_in     (tick_in),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_phase   (cfg_phase),
      .cfg_duty    (cfg_duty),
      .cfg_enable  (cfg_enable),
      .pwm_out     (pwm_out),
`ifdef PWM_COMPLEMENT_EN
      .pwm_out_n   (pwm_out_n),
`endif
      .period_start(period_start)
   );

   always #5 clock_in = ~clock_in;

   initial begin
      #2;
      forever begin
         tick_in = 1'b1;
         #20;
         tick_in = 1'b0;
         #20;
      end
   end

   // caller sits at a negedge; returns at the negedge after the transfer
   task automatic send_cfg(input logic [3:0] ph, input logic [3:0] du, input logic en);
      int n = 0;
      cfg_phase = ph;
      cfg_duty = du;
      cfg_enable = en;
      cfg_valid = 1'b1;
      while (!cfg_ready && n < 100) begin
         @(negedge clock_in);
         n++;
      end
      @(posedge clock_in);
      #1 cfg_valid = 1'b0;
      @(negedge clock_in);
      checks++;
      if (cfg_ready !== 1'b0) begin
         failures++;
         $display("FAIL cfg_ready_drop got=%b exp=0", cfg_ready);
      end
   endtask

   task automatic wait_wrap(input string name);
      int n = 0;
      do begin
         @(negedge clock_in);
         n++;
      end while (!period_start && n < 60);
      checks++;
      if (period_start !== 1'b1) begin
         failures++;
         $display("FAIL %s wrap_timeout got=%b exp=1", name, period_start);
      end
   endtask

   // caller sits at the negedge of a period_start cycle; pat bit k is the level for cnt=k
   task automatic measure(input string name, input logic [7:0] pat);
      logic [32:1] obs, exp, ps, mask;
`ifdef PWM_COMPLEMENT_EN
      logic [32:1] obs_n;
`endif
      mask = '1;
      for (int j = 1; j <= 32; j++) begin
         @(negedge clock_in);
         cfg_valid = 1'b0;
         obs[j] = pwm_out;
         ps[j] = period_start;
`ifdef PWM_COMPLEMENT_EN
         obs_n[j] = pwm_out_n;
         exp[j] = (j >= 3) & pat[(j-1)/4] & pat[(j-2)/4] & pat[(j-3)/4];
`else
         exp[j] = pat[(j-1)/4];
`endif
      end
`ifdef PWM_COMPLEMENT_EN
      mask[1] = 1'b0;
      mask[2] = 1'b0;
      checks++;
      if ((obs & obs_n) !== '0) begin
         failures++;
         $display("FAIL %s overlap got=%h exp=0", name, obs & obs_n);
      end
`endif
      checks++;
      if ((obs & mask) !== (exp & mask)) begin
         failures++;
         $display("FAIL %s pwm_out got=%h exp=%h", name, obs & mask, exp & mask);
      end
      checks++;
      if (ps !== 32'h8000_0000) begin
         failures++;
         $display("FAIL %s period_start got=%h exp=80000000", name, ps);
      end
   endtask

   task automatic test_reset;
      #1 reset = 1'b0;
      repeat (3) @(negedge clock_in);
      checks++;
      if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
      checks++;
      if (period_start !== 1'b0) begin failures++; $display("FAIL reset_ps got=%b exp=0", period_start); end
      checks++;
      if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
`ifdef PWM_COMPLEMENT_EN
      checks++;
      if (pwm_out_n !== 1'b0) begin failures++; $display("FAIL reset_pwm_n got=%b exp=0", pwm_out_n); end
`endif
      reset = 1'b1;
   endtask

   task automatic test_basic;
      int n = 0;
      logic saw = 1'b0, last_ready = 1'b1;
      send_cfg(4'd0, 4'd4, 1'b1);
      do begin
         last_ready = cfg_ready;
         @(negedge clock_in);
         n++;
         saw |= pwm_out;
      end while (!period_start && n < 60);
      checks++;
      if (period_start !== 1'b1) begin failures++; $display("FAIL basic_wrap got=%b exp=1", period_start); end
      checks++;
      if (saw !== 1'b0) begin failures++; $display("FAIL basic_pre_apply_pwm got=%b exp=0", saw); end
      checks++;
      if (last_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_before_wrap got=%b exp=0", last_ready); end
      checks++;
      if (cfg_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after_wrap got=%b exp=1", cfg_ready); end
      measure("basic_p1", 8'h0F);
      measure("basic_p2", 8'h0F);
   endtask

   task automatic test_wrap_phase;
      send_cfg(4'd6, 4'd4, 1'b1);
      wait_wrap("phase6");
      measure("phase6", 8'hC3);
   endtask

   task automatic test_back_to_back;
      int n = 0;
      send_cfg(4'd1, 4'd2, 1'b1);
      cfg_phase = 4'd2;
      cfg_duty = 4'd3;
      cfg_enable = 1'b1;
      cfg_valid = 1'b1;
      do begin
         @(negedge clock_in);
         n++;
      end while (!cfg_ready && n < 60);
      checks++;
      if (cfg_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_timeout got=%b exp=1", cfg_ready); end
      checks++;
      if (period_start !== 1'b1) begin failures++; $display("FAIL b2b_accept_after_wrap got=%b exp=1", period_start); end
      measure("b2b_first", 8'h06);
      measure("b2b_second", 8'h1C);
   endtask

   task automatic test_duty_limits;
      send_cfg(4'd0, 4'd0, 1'b1);
      wait_wrap("duty0");
      measure("duty0", 8'h00);
      send_cfg(4'd0, 4'd12, 1'b1);
      wait_wrap("duty12");
      measure("duty12", 8'hFF);
      send_cfg(4'd12, 4'd4, 1'b1);
      wait_wrap("phase12");
      measure("phase12", 8'h87);
   endtask

   task automatic test_reset_mid;
      int n = 0;
      logic saw = 1'b0, ready_low = 1'b0;
      send_cfg(4'd3, 4'd4, 1'b1);
      @(negedge clock_in);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (pwm_out !== 1'b0) begin failures++; $display("FAIL mid_reset_pwm got=%b exp=0", pwm_out); end
      checks++;
      if (period_start !== 1'b0) begin failures++; $display("FAIL mid_reset_ps got=%b exp=0", period_start); end
      checks++;
      if (cfg_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", cfg_ready); end
      repeat (3) @(negedge clock_in);
      reset = 1'b1;
      do begin
         @(negedge clock_in);
         n++;
         saw |= pwm_out;
         ready_low |= ~cfg_ready;
      end while (!period_start && n < 60);
      checks++;
      if (n < 30 || n > 35) begin failures++; $display("FAIL mid_reset_restart cycles=%0d exp=30..35", n); end
      checks++;
      if (saw !== 1'b0) begin failures++; $display("FAIL mid_reset_pwm_after got=%b exp=0", saw); end
      checks++;
      if (ready_low !== 1'b0) begin failures++; $display("FAIL mid_reset_ready_after got=%b exp=0", ready_low); end
      measure("post_reset_disabled", 8'h00);
   endtask

`ifdef PWM_COMPLEMENT_EN
   task automatic test_complement;
      logic [32:1] obs, obs_n;
      send_cfg(4'd0, 4'd4, 1'b1);
      wait_wrap("cmp");
      for (int p = 0; p < 2; p++) begin
         for (int j = 1; j <= 32; j++) begin
            @(negedge clock_in);
            obs[j] = pwm_out;
            obs_n[j] = pwm_out_n;
         end
         checks++;
         if (obs !== 32'h0000_FFFC) begin failures++; $display("FAIL cmp_pwm p%0d got=%h exp=0000fffc", p, obs); end
         checks++;
         if (obs_n !== 32'hFFFC_0000) begin failures++; $display("FAIL cmp_pwm_n p%0d got=%h exp=fffc0000", p, obs_n); end
         checks++;
         if ((obs & obs_n) !== '0) begin failures++; $display("FAIL cmp_overlap p%0d got=%h exp=0", p, obs & obs_n); end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_wrap_phase;
      test_back_to_back;
      test_duty_limits;
      test_reset_mid;
`ifdef PWM_COMPLEMENT_EN
      test_complement;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
